// File: rtl/mdu_pkg.sv
// Shared constants and state encoding for the MIPS multiply/divide unit sequencer.
package mdu_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_t;

    // Iteration counter width for a given operand width.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/mdu_shift_add_dp.sv
// Shift-add multiplier datapath: operand registers, carry-preserving adder and accumulator shifter.
module mdu_shift_add_dp
    import mdu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               load,
    input  logic               add_en,
    input  logic               shift,
    input  logic [WIDTH-1:0]   mcand_in,
    input  logic [WIDTH-1:0]   mplier_in,
    output logic               mplier_lsb,
    output logic [2*WIDTH-1:0] acc
);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH:0]   upper_sum;

    // Keep the carry out of the upper half so it shifts back into acc.
    assign upper_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (add_en ? mcand : '0)};
    assign mplier_lsb = mplier[0];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (load) begin
            mcand  <= mcand_in;
            mplier <= mplier_in;
            acc    <= '0;
        end else if (shift) begin
            acc    <= {upper_sum, acc[WIDTH-1:1]};
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/mdu_mult_sequencer.sv
// MULT/MULTU sequencer: FSM, sign handling, HI/LO registers and HI/LO hazard stall.
module mdu_mult_sequencer
    import mdu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Rd_hilo,
    input  logic             Wr_hi,
    input  logic             Wr_lo,
    input  logic [WIDTH-1:0] Wr_data,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = cnt_width(WIDTH);

    mdu_state_t state, state_nxt;
    logic [CW-1:0]      cnt;
    logic               neg;
    logic               load, add_en, shift, last_iter;
    logic               mplier_lsb;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc, acc_fixed;

    // Negating the most negative value yields 2^(WIDTH-1), still a valid unsigned magnitude.
    assign a_mag     = (Signed && A[WIDTH-1]) ? -A : A;
    assign b_mag     = (Signed && B[WIDTH-1]) ? -B : B;
    assign acc_fixed = neg ? -acc : acc;
    assign last_iter = (cnt == CW'(WIDTH-1));

    assign Busy  = (state != IDLE);
    assign Stall = Busy && (Start || Rd_hilo || Wr_hi || Wr_lo);
    assign Done  = (state == DONE);

    mdu_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .Clk        (Clk),
        .Rst        (Rst),
        .load       (load),
        .add_en     (add_en),
        .shift      (shift),
        .mcand_in   (a_mag),
        .mplier_in  (b_mag),
        .mplier_lsb (mplier_lsb),
        .acc        (acc)
    );

    always_comb begin
        state_nxt = IDLE;
        load      = 1'b0;
        add_en    = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                load      = Start;
                state_nxt = Start ? ITER : IDLE;
            end
            ITER: begin
                add_en    = mplier_lsb;
                shift     = 1'b1;
                state_nxt = last_iter ? FIX : ITER;
            end
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
            cnt   <= '0;
            neg   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                cnt <= '0;
                neg <= Signed && (A[WIDTH-1] ^ B[WIDTH-1]);
            end else if (shift) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // MTHI/MTLO only land in IDLE, and a simultaneous Start takes priority.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Hi <= '0;
            Lo <= '0;
        end else if (state == FIX) begin
            {Hi, Lo} <= acc_fixed;
        end else if (state == IDLE && !Start) begin
            if (Wr_hi) Hi <= Wr_data;
            if (Wr_lo) Lo <= Wr_data;
        end
    end

endmodule

// File: tb/tb_mdu_mult_sequencer.sv
// Self-checking bench for mdu_mult_sequencer: per-cycle model comparison plus literal checks.
module tb_mdu_mult_sequencer;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         Start = 1'b0, Signed = 1'b0, Rd_hilo = 1'b0, Wr_hi = 1'b0, Wr_lo = 1'b0;
    logic [W-1:0] A = '0, B = '0, Wr_data = '0;
    logic         Busy, Stall, Done;
    logic [W-1:0] Hi, Lo;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model state: busy cycles remaining, architectural HI/LO, pending product.
    int          m_rem = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;
    logic [2*W-1:0] m_pend = '0;

    mdu_mult_sequencer #(.WIDTH(W)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Signed(Signed), .A(A), .B(B),
        .Rd_hilo(Rd_hilo), .Wr_hi(Wr_hi), .Wr_lo(Wr_lo), .Wr_data(Wr_data),
        .Busy(Busy), .Stall(Stall), .Done(Done), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clk = ~Clk;

    function automatic logic [2*W-1:0] product(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa, sb;
        if (s) begin
            sa = {{W{a[W-1]}}, a};
            sb = {{W{b[W-1]}}, b};
            return sa * sb;
        end
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted multiply occupies LAT cycles; HI/LO take the product entering the last one.
    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m_rem = 0; m_hi = '0; m_lo = '0; m_pend = '0;
        end else if (m_rem == 0) begin
            if (Start) begin
                m_pend = product(Signed, A, B);
                m_rem  = LAT;
            end else begin
                if (Wr_hi) m_hi = Wr_data;
                if (Wr_lo) m_lo = Wr_data;
            end
        end else begin
            m_rem--;
            if (m_rem == 1) {m_hi, m_lo} = m_pend;
        end
    end

    always @(negedge Clk) begin
        if (chk_en && !Rst) begin
            check("busy",  {63'd0, Busy},  {63'd0, m_rem != 0});
            check("done",  {63'd0, Done},  {63'd0, m_rem == 1});
            check("stall", {63'd0, Stall}, {63'd0, (m_rem != 0) && (Start || Rd_hilo || Wr_hi || Wr_lo)});
            check("hi",    {32'd0, Hi},    {32'd0, m_hi});
            check("lo",    {32'd0, Lo},    {32'd0, m_lo});
        end
    end

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    // Issue a multiply and count cycles until Done (bounded).
    task automatic do_mult(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, output int n);
        Start = 1'b1; Signed = s; A = a; B = b;
        step();
        Start = 1'b0;
        n = 1;
        while (!Done && n < LAT + 6) begin
            step();
            n++;
        end
    endtask

    int n;

    initial begin
        step(); step();
        check("reset_busy", {63'd0, Busy}, 64'd0);
        check("reset_done", {63'd0, Done}, 64'd0);
        check("reset_hilo", {Hi, Lo}, 64'd0);
        Rst = 1'b0;
        chk_en = 1'b1;
        step();

        // 1: MULTU all-ones
        do_mult(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        check("t1_latency", n, 34);
        check("t1_hilo", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);
        step();

        // 2: signed cases
        do_mult(1'b1, 32'hFFFF_FFFD, 32'd5, n);
        check("t2_neg", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        step();
        do_mult(1'b1, 32'h8000_0000, 32'h8000_0000, n);
        check("t2_minmin", {Hi, Lo}, 64'h4000_0000_0000_0000);
        step();
        do_mult(1'b1, 32'h8000_0000, 32'd1, n);
        check("t2_min_x1", {Hi, Lo}, 64'hFFFF_FFFF_8000_0000);
        step();
        do_mult(1'b1, 32'd7, 32'hFFFF_FFFF, n);
        check("t2_pos_neg", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFF9);
        step();

        // 3: zero operand, no early exit
        do_mult(1'b1, 32'd0, 32'h1234, n);
        check("t3_latency", n, 34);
        check("t3_hilo", {Hi, Lo}, 64'd0);
        step();
        check("t3_idle", {63'd0, Busy}, 64'd0);

        // 4: MFHI stall and held Start
        Start = 1'b1; Signed = 1'b0; A = 32'd100; B = 32'd3;
        step();
        Start = 1'b0;
        repeat (4) step();
        Start = 1'b1; A = 32'd9; B = 32'd11; Rd_hilo = 1'b1;
        n = 5;
        while (!Done && n < LAT + 6) begin
            step();
            n++;
        end
        check("t4_latency", n, 34);
        check("t4_stall_done", {63'd0, Stall}, 64'd1);
        check("t4_first", {Hi, Lo}, 64'd300);
        step();
        check("t4_stall_idle", {63'd0, Stall}, 64'd0);
        check("t4_idle", {63'd0, Busy}, 64'd0);
        step();
        Start = 1'b0; Rd_hilo = 1'b0;
        check("t4_accept", {63'd0, Busy}, 64'd1);
        n = 1;
        while (!Done && n < LAT + 6) begin
            step();
            n++;
        end
        check("t4_second", {Hi, Lo}, 64'd99);
        step();

        // 5: MTHI in idle, then Start beats MTLO
        Wr_hi = 1'b1; Wr_data = 32'hA5A5_A5A5;
        step();
        Wr_hi = 1'b0;
        check("t5_mthi", {Hi, Lo}, {32'hA5A5_A5A5, 32'd99});
        Wr_lo = 1'b1; Wr_data = 32'hDEAD_BEEF;
        Start = 1'b1; Signed = 1'b0; A = 32'd3; B = 32'd4;
        step();
        Start = 1'b0; Wr_lo = 1'b0;
        n = 1;
        while (!Done && n < LAT + 6) begin
            step();
            n++;
        end
        check("t5_start_wins", {Hi, Lo}, 64'd12);
        step();
        Wr_hi = 1'b1; Wr_lo = 1'b1; Wr_data = 32'h1357_9BDF;
        step();
        Wr_hi = 1'b0; Wr_lo = 1'b0;
        check("t5_both", {Hi, Lo}, 64'h1357_9BDF_1357_9BDF);

        // 6: async reset mid-iteration
        Start = 1'b1; Signed = 1'b0; A = 32'h1234_5678; B = 32'h9ABC_DEF0;
        step();
        Start = 1'b0;
        repeat (10) step();
        #1 Rst = 1'b1;
        #1;
        check("t6_busy", {63'd0, Busy}, 64'd0);
        check("t6_hilo", {Hi, Lo}, 64'd0);
        Rst = 1'b0;
        n = 0;
        repeat (40) begin
            step();
            if (Done) n++;
        end
        check("t6_no_done", n, 0);
        do_mult(1'b0, 32'd7, 32'd6, n);
        check("t6_after", {Hi, Lo}, 64'd42);
        step(); step();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
